// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 0..9999 value shown by a 4-digit multiplexed
// 7-segment driver from its active-low sel/seg buses.
//
// Digits are sampled once per dwell, after sel has been stable for SETTLE
// cycles. A small FSM checks that the digits arrive in the order
// thousands -> hundreds -> tens -> ones. Each complete frame is converted to
// binary. A timeout flags a display that has stopped scanning.

// Per-digit holding register, loaded when its scan position is accepted.
module seg_scan_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q
);
  // hold the accepted BCD digit until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= 4'd0;
    else if (ld) q <= d;
  end
endmodule

module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 8,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  sel_in,
  output logic [13:0] dat,
  output logic        dat_vld,
  output logic        err,
  output logic        stale
);
  localparam logic [15:0] SETTLE_C = 16'(SETTLE);
  localparam logic [31:0] TO_C     = 32'(TIMEOUT);

  localparam logic [3:0] SEL_TH = 4'b1110;
  localparam logic [3:0] SEL_HU = 4'b1101;
  localparam logic [3:0] SEL_TE = 4'b1011;
  localparam logic [3:0] SEL_ON = 4'b0111;

  typedef enum logic [2:0] {SYNC, EXP_TH, EXP_HU, EXP_TE, EXP_ON} state_t;

  // {valid, digit}; the code must match exactly, with dp off
  function automatic logic [4:0] seg_dec(input logic [7:0] s);
    case (s)
      8'hc0:   seg_dec = {1'b1, 4'd0};
      8'hf9:   seg_dec = {1'b1, 4'd1};
      8'ha4:   seg_dec = {1'b1, 4'd2};
      8'hb0:   seg_dec = {1'b1, 4'd3};
      8'h99:   seg_dec = {1'b1, 4'd4};
      8'h92:   seg_dec = {1'b1, 4'd5};
      8'h82:   seg_dec = {1'b1, 4'd6};
      8'hf8:   seg_dec = {1'b1, 4'd7};
      8'h80:   seg_dec = {1'b1, 4'd8};
      8'h90:   seg_dec = {1'b1, 4'd9};
      default: seg_dec = {1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0]  seg_q;
  logic [3:0]  sel_q, sel_p;
  logic [15:0] set_cnt;
  logic [31:0] to_cnt;
  state_t      state, nxt;

  logic        strobe, to_hit, sel_legal, hit, dec_ok;
  logic [3:0]  dec_val, exp_sel;
  logic [4:0]  dec;
  logic [1:0]  idx;
  logic [3:1]  ld;
  logic [3:1][3:0] dig;
  logic [13:0] sum;

  // register the bus once; sel_p is the previous sel_q for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 8'd0;
      sel_q <= 4'd0;
      sel_p <= 4'd0;
    end else begin
      seg_q <= seg_in;
      sel_q <= sel_in;
      sel_p <= sel_q;
    end
  end

  // settle counter: restarts on every sel change and saturates at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                set_cnt <= 16'd0;
    else if (sel_q != sel_p)   set_cnt <= 16'd0;
    else if (set_cnt != '1)    set_cnt <= set_cnt + 16'd1;
  end

  // A sel change in the same cycle beats the count match.
  // Because the counter saturates above SETTLE, each dwell strobes at most once.
  assign strobe = (set_cnt == SETTLE_C) && (sel_q == sel_p);

  // cycles since the last strobe, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             to_cnt <= 32'd0;
    else if (strobe)        to_cnt <= 32'd0;
    else if (to_cnt != '1)  to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit = (to_cnt == TO_C) && !strobe;

  assign dec     = seg_dec(seg_q);
  assign dec_ok  = dec[4];
  assign dec_val = dec[3:0];

  assign sel_legal = (sel_q == SEL_TH) || (sel_q == SEL_HU) ||
                     (sel_q == SEL_TE) || (sel_q == SEL_ON);

  // Derive the expected select, the digit slot and the next state from the current state.
  // SYNC looks for a thousands digit.
  always_comb begin
    exp_sel = SEL_TH;
    idx     = 2'd3;
    nxt     = EXP_HU;
    case (state)
      EXP_HU:  begin exp_sel = SEL_HU; idx = 2'd2; nxt = EXP_TE; end
      EXP_TE:  begin exp_sel = SEL_TE; idx = 2'd1; nxt = EXP_ON; end
      EXP_ON:  begin exp_sel = SEL_ON; idx = 2'd0; nxt = EXP_TH; end
      default: begin exp_sel = SEL_TH; idx = 2'd3; nxt = EXP_HU; end
    endcase
  end

  assign hit = strobe && (sel_q == exp_sel) && dec_ok;

  // The ones digit goes straight into the conversion, so only three digits are held.
  genvar gi;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_dig
      assign ld[gi] = hit && (idx == 2'(gi));
      seg_scan_digit u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld[gi]),
        .d     (dec_val),
        .q     (dig[gi])
      );
    end
  endgenerate

  // Even 9999 fits in 14 bits, so no product or sum overflows.
  assign sum = {10'd0, dig[3]} * 14'd1000 + {10'd0, dig[2]} * 14'd100 +
               {10'd0, dig[1]} * 14'd10   + {10'd0, dec_val};

  // frame FSM with registered dat/dat_vld/err/stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      dat     <= 14'd0;
      dat_vld <= 1'b0;
      err     <= 1'b0;
      stale   <= 1'b1;
    end else begin
      dat_vld <= 1'b0;
      err     <= 1'b0;
      if (to_hit) begin
        stale <= 1'b1;
        state <= SYNC;
      end else if (strobe) begin
        if (state == SYNC) begin
          if (hit)
            state <= nxt;
          else if (!sel_legal || (sel_q == SEL_TH && !dec_ok))
            err <= 1'b1;
        end else if (hit) begin
          state <= nxt;
          if (state == EXP_ON) begin
            dat     <= sum;
            dat_vld <= 1'b1;
            stale   <= 1'b0;
          end
        end else begin
          err   <= 1'b1;
          state <= SYNC;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: the bench drives the scanned display.
// A negedge monitor counts dat_vld and err pulses.
`timescale 1ns/1ps
module tb_seg_scan_decoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_in = 8'hff;
  logic [3:0]  sel_in = 4'b1110;
  logic [13:0] dat;
  logic        dat_vld, err, stale;

  int total = 0, bad = 0;
  int vld_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [13:0] last_dat = '0;
  longint t_last = 0, t_prev = 0;

  seg_scan_decoder #(.SETTLE(8), .TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .sel_in(sel_in),
    .dat(dat), .dat_vld(dat_vld), .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  // pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_vld) begin
        vld_cnt++;
        last_dat = dat;
        t_prev = t_last;
        t_last = $time;
      end
      if (err) err_cnt++;
      if (dat_vld && err) both_cnt++;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: seg_of = 8'hc0; 1: seg_of = 8'hf9; 2: seg_of = 8'ha4; 3: seg_of = 8'hb0;
      4: seg_of = 8'h99; 5: seg_of = 8'h92; 6: seg_of = 8'h82; 7: seg_of = 8'hf8;
      8: seg_of = 8'h80; default: seg_of = 8'h90;
    endcase
  endfunction

  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int dwell);
    @(negedge clk);
    sel_in = sel;
    seg_in = seg;
    repeat (dwell - 1) @(negedge clk);
  endtask

  // k = 0 thousands .. 3 ones
  function automatic int digit_of(input int v, input int k);
    case (k)
      0: digit_of = (v / 1000) % 10;
      1: digit_of = (v / 100) % 10;
      2: digit_of = (v / 10) % 10;
      default: digit_of = v % 10;
    endcase
  endfunction

  task automatic frame(input int v, input int dwell, input int bad_k);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] s;
      s = ~(4'b0001 << k);
      drive(s, (k == bad_k) ? 8'hff : seg_of(digit_of(v, k)), dwell);
    end
  endtask

  initial begin
    int v0, e0, n;
    int vals[4];
    vals = '{0, 9999, 7, 1000};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dat", dat, 0);
    chk("rst_vld", dat_vld, 0);
    chk("rst_err", err, 0);
    chk("rst_stale", stale, 1);
    rst_n = 1'b1;
    chk("stale_before_frame", stale, 1);

    // 1234 at dwell 20
    frame(1234, 20, -1);
    chk("first_vld_cnt", vld_cnt, 1);
    chk("first_dat", last_dat, 1234);
    chk("stale_after_first", stale, 0);
    frame(1234, 20, -1);
    frame(1234, 20, -1);
    chk("vld_cnt_3frames", vld_cnt, 3);
    chk("vld_period_ns", t_last - t_prev, 800);
    chk("err_none_1234", err_cnt, 0);

    // value sweep
    foreach (vals[i]) begin
      v0 = vld_cnt;
      repeat (3) frame(vals[i], 20, -1);
      chk("sweep_vld", vld_cnt - v0, 3);
      chk("sweep_dat", dat, vals[i]);
    end
    chk("sweep_no_err", err_cnt, 0);

    // bad tens code
    v0 = vld_cnt; e0 = err_cnt;
    frame(4321, 20, 2);
    chk("badseg_err", err_cnt - e0, 1);
    chk("badseg_no_vld", vld_cnt - v0, 0);
    chk("badseg_dat_hold", dat, 1000);
    frame(5678, 20, -1);
    chk("badseg_resume_vld", vld_cnt - v0, 1);
    chk("badseg_resume_dat", dat, 5678);

    // order skip, then ones in SYNC is ignored
    e0 = err_cnt;
    drive(4'b1110, seg_of(1), 20);
    drive(4'b1011, seg_of(2), 20);
    chk("skip_err", err_cnt - e0, 1);
    drive(4'b0111, seg_of(3), 20);
    chk("sync_ignore_ones", err_cnt - e0, 1);
    drive(4'b1100, seg_of(3), 20);
    chk("illegal_sel_err", err_cnt - e0, 2);
    v0 = vld_cnt;
    frame(4321, 20, -1);
    chk("after_err_dat", dat, 4321);
    chk("after_err_vld", vld_cnt - v0, 1);

    // short dwell: no strobes at all
    v0 = vld_cnt; e0 = err_cnt;
    repeat (15) frame(8888, 5, -1);
    chk("short_no_vld", vld_cnt - v0, 0);
    chk("short_no_err", err_cnt - e0, 0);
    chk("short_stale", stale, 1);

    // frozen at hundreds
    frame(2468, 20, -1);
    chk("refresh_stale", stale, 0);
    e0 = err_cnt;
    drive(4'b1110, seg_of(1), 20);
    @(negedge clk);
    sel_in = 4'b1101;
    seg_in = seg_of(2);
    n = 0;
    while (!stale && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("freeze_stale", stale, 1);
    chk("freeze_delay_ok", (n >= 205 && n <= 220) ? 1 : 0, 1);
    chk("freeze_no_err", err_cnt - e0, 0);
    v0 = vld_cnt;
    frame(1357, 20, -1);
    chk("post_freeze_vld", vld_cnt - v0, 1);
    chk("post_freeze_dat", dat, 1357);
    chk("post_freeze_stale", stale, 0);

    // reset mid-frame
    drive(4'b1110, seg_of(5), 20);
    drive(4'b1101, seg_of(5), 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dat", dat, 0);
    chk("midrst_stale", stale, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vld_cnt; e0 = err_cnt;
    drive(4'b1011, seg_of(5), 20);
    drive(4'b0111, seg_of(5), 20);
    chk("midrst_partial_no_vld", vld_cnt - v0, 0);
    chk("midrst_partial_no_err", err_cnt - e0, 0);
    frame(9081, 20, -1);
    chk("midrst_next_vld", vld_cnt - v0, 1);
    chk("midrst_next_dat", dat, 9081);

    chk("never_vld_and_err", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
